// File: rtl/key_expander_pkg.sv
// key_expander_pkg -- constants and types shared by the AES-128 key expander
// and the encryptor that consumes its round keys.
//   AES_NR     : number of rounds (10 for AES-128)
//   AES_KEY_W  : key / round-key width in bits
//   AES_NSLOT  : number of stored round keys (round 0..AES_NR)
//   AES_RCON   : round constants, index 0 unused, 1..10 valid
//   state_t    : expander FSM encoding
//   rot_word() : cyclic left rotate of a 32-bit word by one byte
package key_expander_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;
  localparam int AES_NSLOT = AES_NR + 1;

  // Rcon[r] occupies the most significant byte of the word it is XORed into.
  localparam logic [7:0] AES_RCON [0:AES_NR] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // RotWord([a0,a1,a2,a3]) = [a1,a2,a3,a0], a0 being the most significant byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expander_if.sv
// key_expander_if -- request/read bus of the key expander.
//   start  : request expansion of key
//   key    : AES-128 cipher key, bit 127 = MSB of first byte
//   rd_idx : round-key select (0..10; 11..15 read as zero)
//   rd_key : selected round key, same byte order as key
//   busy   : expansion in progress
//   ready  : all 11 round keys valid and stable
// master = requester (encryptor / bench), slave = key_expander.
interface key_expander_if;
  import key_expander_pkg::*;

  logic                 start;
  logic [AES_KEY_W-1:0] key;
  logic [3:0]           rd_idx;
  logic [AES_KEY_W-1:0] rd_key;
  logic                 busy;
  logic                 ready;

  modport master (
    output start, key, rd_idx,
    input  rd_key, busy, ready
  );

  modport slave (
    input  start, key, rd_idx,
    output rd_key, busy, ready
  );

endinterface

// File: rtl/key_expander_sbox.sv
// aes_sbox -- AES forward S-box, purely combinational.
//   in_byte  : input byte
//   out_byte : SubBytes(in_byte)
// Shared with the encryptor's SubBytes datapath.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_expander.sv
// key_expander -- iterative AES-128 key schedule, one round key per cycle.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; clears FSM and all round-key slots
//   bus : key_expander_if.slave (start/key in, rd_idx/rd_key read port,
//         busy/ready status)
// A start in IDLE or DONE loads the key into slot 0 (edge E_0); slots 1..10
// are written on the following ten edges and ready rises on E_10.
module key_expander
  import key_expander_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  key_expander_if.slave bus
);

  state_t               state_reg;
  logic [3:0]           rnd_reg;
  logic                 busy_reg;
  logic                 ready_reg;
  logic [AES_KEY_W-1:0] slot_reg [AES_NSLOT];

  logic                 load;
  logic                 expand_we;
  logic [AES_KEY_W-1:0] prev_key;
  logic [31:0]          rot_w;
  logic [31:0]          sub_w;
  logic [7:0]           rcon_b;
  logic [31:0]          n0, n1, n2, n3;
  logic [AES_KEY_W-1:0] next_key;
  logic [AES_KEY_W-1:0] rd_key_c;

  // start is only honoured outside EXPAND; during EXPAND it is ignored.
  assign load      = bus.start && (state_reg != EXPAND);
  assign expand_we = (state_reg == EXPAND);

  // Previous round key (slot rnd-1) and Rcon[rnd]; zero outside 1..10.
  always_comb begin
    prev_key = '0;
    rcon_b   = 8'h00;
    for (int i = 1; i < AES_NSLOT; i++) begin
      if (rnd_reg == 4'(i)) begin
        prev_key = slot_reg[i-1];
        rcon_b   = AES_RCON[i];
      end
    end
  end

  assign rot_w = rot_word(prev_key[31:0]);

  // SubWord: one S-box per byte of the rotated last word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*gi +: 8]),
      .out_byte (sub_w[8*gi +: 8])
    );
  end

  assign n0       = prev_key[127:96] ^ sub_w ^ {rcon_b, 24'h000000};
  assign n1       = prev_key[95:64]  ^ n0;
  assign n2       = prev_key[63:32]  ^ n1;
  assign n3       = prev_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Round-key storage: cleared asynchronously so no partial schedule
  // survives an aborted expansion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AES_NSLOT; i++) begin
        slot_reg[i] <= '0;
      end
    end else if (load) begin
      slot_reg[0] <= bus.key;
    end else if (expand_we) begin
      for (int i = 1; i < AES_NSLOT; i++) begin
        if (rnd_reg == 4'(i)) begin
          slot_reg[i] <= next_key;
        end
      end
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rnd_reg   <= 4'd0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            state_reg <= EXPAND;
            rnd_reg   <= 4'd1;
            busy_reg  <= 1'b1;
            ready_reg <= 1'b0;
          end
        end
        EXPAND: begin
          if (rnd_reg == 4'(AES_NR)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end else begin
            rnd_reg <= rnd_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          rnd_reg   <= 4'd0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read port; indices above 10 read as zero.
  always_comb begin
    rd_key_c = '0;
    for (int i = 0; i < AES_NSLOT; i++) begin
      if (bus.rd_idx == 4'(i)) begin
        rd_key_c = slot_reg[i];
      end
    end
  end

  assign bus.rd_key = rd_key_c;
  assign bus.busy   = busy_reg;
  assign bus.ready  = ready_reg;

endmodule

// File: tb/tb_key_expander.sv
// tb_key_expander -- directed self-checking bench for key_expander using
// FIPS-197 key schedule vectors.
module tb_key_expander;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  key_expander_if kif ();

  key_expander u_dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%032h exp=%032h", tag, obs, exp);
    end else begin
      $display("ok   %s = %032h", tag, obs);
    end
  endtask

  task automatic check_rd(input string tag, input logic [3:0] idx,
                          input logic [127:0] exp);
    kif.rd_idx = idx;
    #1;
    check_val($sformatf("%s_rd%0d", tag, idx), kif.rd_key, exp);
  endtask

  task automatic check_status(input string tag, input logic exp_busy,
                              input logic exp_ready);
    check_val({tag, "_busy"},  {127'd0, kif.busy},  {127'd0, exp_busy});
    check_val({tag, "_ready"}, {127'd0, kif.ready}, {127'd0, exp_ready});
  endtask

  // Pulse start for one edge (E_0), then follow ten edges checking that
  // ready rises exactly on E_10.
  task automatic run_expand(input string tag, input logic [127:0] k);
    @(negedge clk);
    kif.start = 1'b1;
    kif.key   = k;
    @(negedge clk);
    kif.start = 1'b0;
    kif.key   = '0;
    check_status({tag, "_e0"}, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check_val($sformatf("%s_e%0d_ready", tag, c), {127'd0, kif.ready},
                {127'd0, (c == 10)});
    end
  endtask

  initial begin
    kif.start  = 1'b0;
    kif.key    = '0;
    kif.rd_idx = 4'd0;

    // Reset, then idle state before any start.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_status("idle", 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check_rd("idle", 4'(i), '0);

    // FIPS-197 Appendix A.1 key.
    run_expand("fips", K1);
    check_status("fips_done", 1'b0, 1'b1);
    check_rd("fips", 4'd0, K1);
    check_rd("fips", 4'd1, K1_RK1);
    check_rd("fips", 4'd2, K1_RK2);
    check_rd("fips", 4'd10, K1_RK10);

    // Restart from DONE with a new key; ready falls on the start edge.
    run_expand("restart", K2);
    check_rd("restart", 4'd0, K2);
    check_rd("restart", 4'd1, K2_RK1);
    check_rd("restart", 4'd10, K2_RK10);
    check_rd("restart", 4'd11, '0);
    check_rd("restart", 4'd15, '0);

    // start held for four edges, key changed after E_1: only K1 counts.
    @(negedge clk);
    kif.start = 1'b1;
    kif.key   = K1;
    @(negedge clk);
    check_status("hold_e0", 1'b1, 1'b0);
    @(negedge clk);
    kif.key = K2;
    repeat (2) @(negedge clk);
    kif.start = 1'b0;
    for (int c = 4; c <= 10; c++) begin
      @(negedge clk);
      check_val($sformatf("hold_e%0d_ready", c), {127'd0, kif.ready},
                {127'd0, (c == 10)});
    end
    check_rd("hold", 4'd0, K1);
    check_rd("hold", 4'd1, K1_RK1);
    check_rd("hold", 4'd10, K1_RK10);

    // Abort mid-expansion with an asynchronous reset.
    @(negedge clk);
    kif.start = 1'b1;
    kif.key   = K1;
    @(negedge clk);
    kif.start = 1'b0;
    repeat (4) @(negedge clk);
    check_status("abort_pre", 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_status("abort", 1'b0, 1'b0);
    for (int i = 0; i <= 10; i++) check_rd("abort", 4'(i), '0);

    // start while rst is high is ignored.
    @(negedge clk);
    kif.start = 1'b1;
    kif.key   = K2;
    @(negedge clk);
    check_status("rst_start", 1'b0, 1'b0);
    check_rd("rst_start", 4'd0, '0);

    // First edge with rst low accepts the held start.
    rst = 1'b0;
    @(negedge clk);
    kif.start = 1'b0;
    kif.key   = '0;
    check_status("post_rst_e0", 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check_status("post_rst_done", 1'b0, 1'b1);
    check_rd("post_rst", 4'd10, K2_RK10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
